// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

  // REQ: request to be granted. WAIT: granted, awaiting data.
  // DRAIN: awaiting a response that a redirect has made stale.
  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int unsigned PC_STEP   = 4;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {instr, pc} holding buffer. It catches a response that arrives
// while decode is stalled on a full output slot.
module fetch_skid_buf
  import fetch_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             load,
  input  logic             pop,
  input  logic [31:0]      d_instr,
  input  logic [WIDTH-1:0] d_pc,
  output logic             valid,
  output logic [31:0]      q_instr,
  output logic [WIDTH-1:0] q_pc
);

  // Occupancy: flush wins, then load, then pop (load and pop never coincide).
  always_ff @(posedge clk) begin
    if (rst)        valid <= 1'b0;
    else if (flush) valid <= 1'b0;
    else if (load)  valid <= 1'b1;
    else if (pop)   valid <= 1'b0;
  end

  // Payload is captured on every load. It is only meaningful while valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_instr <= NOP_INSTR;
      q_pc    <= '0;
    end else if (load) begin
      q_instr <= d_instr;
      q_pc    <= d_pc;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC and keeps at most one
// memory request in flight. It applies redirects and delivers {instr, pc}
// to decode through an output slot backed by a one-entry skid buffer.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_target,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [31:0]      imem_rdata,
  output logic             instr_valid,
  output logic [31:0]      instr,
  output logic [WIDTH-1:0] instr_pc
);

  fetch_state_t     state;
  logic [WIDTH-1:0] pc, req_pc, target_al;
  logic             skid_valid;
  logic [31:0]      skid_instr;
  logic [WIDTH-1:0] skid_pc;
  logic             gnt_ok, resp, slot_open, skid_load, skid_pop;
  logic             unused_tgt_lsb;

  // Targets are word aligned. The low two bits are dropped.
  assign target_al      = {redirect_target[WIDTH-1:2], 2'b00};
  assign unused_tgt_lsb = ^redirect_target[1:0];

  // No new request while the skid buffer holds an instruction.
  assign imem_req  = (state == REQ) && !skid_valid;
  assign imem_addr = pc;
  assign gnt_ok    = imem_req && imem_gnt;

  // A response is used only in WAIT. A redirect in the same cycle drops it.
  assign resp      = (state == WAIT) && imem_rvalid && !redirect;
  assign slot_open = !instr_valid || !stall;
  assign skid_load = resp && !slot_open;
  assign skid_pop  = instr_valid && !stall && skid_valid;

  // FSM and PC. A redirect overrides the normal handshake progression.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= REQ;
      pc     <= RESET_PC;
      req_pc <= RESET_PC;
    end else if (redirect) begin
      pc <= target_al;
      unique case (state)
        REQ:     state <= gnt_ok      ? DRAIN : REQ;
        WAIT:    state <= imem_rvalid ? REQ   : DRAIN;
        DRAIN:   state <= imem_rvalid ? REQ   : DRAIN;
        default: state <= REQ;
      endcase
    end else begin
      unique case (state)
        REQ: if (gnt_ok) begin
          req_pc <= pc;
          pc     <= pc + WIDTH'(PC_STEP);
          state  <= WAIT;
        end
        WAIT:    if (imem_rvalid) state <= REQ;
        DRAIN:   if (imem_rvalid) state <= REQ;
        default: state <= REQ;
      endcase
    end
  end

  // Output slot. It holds while stalled and refills from skid before taking
  // fresh data. It clears on consumption when nothing replaces it.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_valid <= 1'b0;
      instr       <= NOP_INSTR;
      instr_pc    <= RESET_PC;
    end else if (redirect) begin
      instr_valid <= 1'b0;
    end else if (slot_open) begin
      if (skid_pop) begin
        instr_valid <= 1'b1;
        instr       <= skid_instr;
        instr_pc    <= skid_pc;
      end else if (resp) begin
        instr_valid <= 1'b1;
        instr       <= imem_rdata;
        instr_pc    <= req_pc;
      end else begin
        instr_valid <= 1'b0;
      end
    end
  end

  fetch_skid_buf #(.WIDTH(WIDTH)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .flush   (redirect),
    .load    (skid_load),
    .pop     (skid_pop),
    .d_instr (imem_rdata),
    .d_pc    (req_pc),
    .valid   (skid_valid),
    .q_instr (skid_instr),
    .q_pc    (skid_pc)
  );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl. It runs directed scenarios followed by a randomized
// run. A transaction-level memory model and delivery-order model produce
// every expected value.
module tb_fetch_ctrl;
  import fetch_pkg::*;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        rst, stall, redirect;
  logic [31:0] redirect_target;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        instr_valid;
  logic [31:0] instr, instr_pc;

  int checks = 0;
  int failures = 0;

  // memory model state
  bit          mem_busy = 0, mem_orphan = 0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = '0;
  int          lat_min = 1, lat_max = 1, gnt_pct = 100;

  // reference model state
  logic [31:0] exp_req = RST_PC, exp_del = RST_PC;
  logic [31:0] prev_instr = '0, prev_pc = '0;
  bit          prev_hold = 0, prev_redir = 0, quiet = 1;
  int          stretch_g = 0;

  fetch_ctrl #(.WIDTH(32), .RESET_PC(RST_PC)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_gnt        (imem_gnt),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .instr_valid     (instr_valid),
    .instr           (instr),
    .instr_pc        (instr_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'hC0DE_5A5A;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle. Memory outputs are driven, outputs are checked against
  // the model, the clock edge passes, and then the model advances.
  task automatic cycle();
    logic        c_rst, c_red, c_stall, c_valid, c_gnt, c_rv;
    logic [31:0] c_tgt, c_instr, c_pc, c_addr;
    imem_rvalid = mem_busy && (mem_cnt == 0);
    imem_rdata  = imem_rvalid ? mem_data(mem_addr) : $urandom;
    imem_gnt    = !rst && !mem_busy && (imem_req === 1'b1) &&
                  ($urandom_range(99) < gnt_pct);
    #1;
    if (!rst) begin
      if (mem_busy && !mem_orphan) chk("req_while_busy", 32'(imem_req), 0);
      if (imem_req) chk("req_addr", imem_addr, exp_req);
      if (prev_redir) chk("valid_after_redirect", 32'(instr_valid), 0);
      if (quiet) chk("quiet_after_reset", 32'(instr_valid), 0);
      if (prev_hold) begin
        chk("hold_valid", 32'(instr_valid), 1);
        chk("hold_instr", instr, prev_instr);
        chk("hold_pc", instr_pc, prev_pc);
      end
      if (instr_valid) chk("instr_data", instr, mem_data(instr_pc));
      if (instr_valid && !stall && !redirect) begin
        chk("deliver_pc", instr_pc, exp_del);
        exp_del = exp_del + 32'd4;
      end
      if (stall && instr_valid && !redirect) begin
        if (imem_req && imem_gnt) begin
          stretch_g++;
          chk("stall_absorb_le1", 32'(stretch_g <= 1), 1);
        end
      end else stretch_g = 0;
    end
    c_rst = rst; c_red = redirect; c_tgt = redirect_target; c_stall = stall;
    c_valid = instr_valid; c_instr = instr; c_pc = instr_pc;
    c_gnt = imem_req && imem_gnt; c_addr = imem_addr; c_rv = imem_rvalid;
    @(posedge clk); #1;
    if (c_rv) begin
      mem_busy = 0;
      if (!mem_orphan) quiet = 0;
      mem_orphan = 0;
    end else if (mem_busy) mem_cnt--;
    if (c_gnt) begin
      mem_busy = 1; mem_addr = c_addr;
      mem_cnt = $urandom_range(lat_max - 1, lat_min - 1);
    end
    if (c_rst) begin
      if (mem_busy) mem_orphan = 1;
      quiet = 1; exp_req = RST_PC; exp_del = RST_PC;
      prev_hold = 0; prev_redir = 0; stretch_g = 0;
    end else begin
      if (c_red) begin
        exp_req = c_tgt & ~32'd3;
        exp_del = c_tgt & ~32'd3;
      end else if (c_gnt) exp_req = exp_req + 32'd4;
      prev_redir = c_red;
      prev_hold  = c_stall && c_valid && !c_red;
      prev_instr = c_instr; prev_pc = c_pc;
    end
  endtask

  initial begin
    int n;
    rst = 1; stall = 0; redirect = 0; redirect_target = '0;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;

    // reset values
    repeat (2) cycle();
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_instr", instr, NOP_INSTR);
    chk("rst_instr_pc", instr_pc, RST_PC);
    chk("rst_req", 32'(imem_req), 1);
    chk("rst_addr", imem_addr, RST_PC);
    rst = 0;

    // zero-wait memory: a valid instruction every other cycle from index 2,
    // starting at RESET_PC and wrapping to 0
    for (int i = 0; i < 7; i++) begin
      cycle();
      chk("zw_valid_pattern", 32'(instr_valid), 32'((i + 1) >= 2 && ((i + 1) % 2) == 0));
    end
    n = 0;
    while (!(instr_valid && instr_pc == 32'd8) && n < 20) begin cycle(); n++; end
    chk("reach_pc8_timeout", 32'(n < 20), 1);

    // hold stall for 6 cycles at pc 8
    stall = 1;
    repeat (6) cycle();
    chk("stall_frozen_pc", instr_pc, 32'd8);
    chk("stall_no_req", 32'(imem_req), 0);
    stall = 0;
    cycle();
    chk("skid_out_valid", 32'(instr_valid), 1);
    chk("skid_out_pc", instr_pc, 32'd12);

    // redirect in the same cycle as the grant for 0x10
    n = 0;
    while (!(imem_req && imem_addr == 32'h10) && n < 20) begin cycle(); n++; end
    chk("reach_req10_timeout", 32'(n < 20), 1);
    redirect = 1; redirect_target = 32'h0000_0103;
    cycle();
    redirect = 0;
    chk("drain_no_req", 32'(imem_req), 0);
    n = 0;
    while (!imem_req && n < 20) begin cycle(); n++; end
    chk("redirect_req_addr", imem_addr, 32'h100);
    n = 0;
    while (!instr_valid && n < 20) begin cycle(); n++; end
    chk("post_redirect_pc", instr_pc, 32'h100);

    // redirect while stalled with the slot and skid both full
    stall = 1;
    repeat (3) cycle();
    redirect = 1; redirect_target = 32'h2000_0046;
    cycle();
    redirect = 0;
    chk("redir_stall_valid", 32'(instr_valid), 0);
    chk("redir_first_req", 32'(imem_req), 1);
    stall = 0;
    n = 0;
    while (!instr_valid && n < 20) begin cycle(); n++; end
    chk("redir_stall_pc", instr_pc, 32'h2000_0044);

    // reset while WAIT, followed by a late response
    lat_min = 4; lat_max = 4;
    n = 0;
    while (!mem_busy && n < 20) begin cycle(); n++; end
    rst = 1;
    cycle();
    rst = 0;
    chk("post_rst_req", 32'(imem_req), 1);
    chk("post_rst_addr", imem_addr, RST_PC);
    n = 0;
    while (!instr_valid && n < 40) begin cycle(); n++; end
    chk("post_rst_first_pc", instr_pc, RST_PC);

    // randomized run
    lat_min = 1; lat_max = 4; gnt_pct = 70;
    for (int i = 0; i < 3000; i++) begin
      stall = ($urandom_range(9) < 3);
      redirect = ($urandom_range(99) < 3);
      redirect_target = $urandom;
      rst = ($urandom_range(999) < 3);
      cycle();
    end
    rst = 0; stall = 0; redirect = 0;
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
